synch_modn_counter_4: RTL and testbench
=======================================

Name: synch_modn_counter_4

Overview:
- Synchronous modulo-N counter clock divider. Produces `clk_out` at f(clk)/N with 50% duty cycle.
- Default N = 4.
- Sits at the clock-generation level. Feeds slower logic domains from the single system clock.

Parameters:
- N, default 4: division ratio. Integer, must be >= 2. N < 2 is a compile/elaboration-time error.
- CW, default $clog2(N): counter width. Derived; not to be overridden.

Ports:
- clk      input   1   system clock. All state advances on the rising edge; odd N also uses the falling edge.
- rst_n    input   1   reset. One clock; reset is asynchronous and active-low.
- clk_out  output  1   divided clock, period N*Tclk, 50% duty.

Behaviour:
- Internal counter `count[CW-1:0]`.
  - On each rising clk edge: `count_next = (count == N-1) ? 0 : count+1`.
  - Wrap is exactly at N-1. Values >= N are never reached.
- Threshold T = ceil(N/2).
- Rising-edge register `p`: `p <= (count_next >= T)`.
  - `p` is high for floor(N/2) clk cycles per N-cycle period.
- Even N: `clk_out = p`.
  - High for exactly N/2 cycles, low for N/2 cycles.
  - `clk_out` is a direct register output (glitch-free).
- Odd N: falling-edge register `n` samples `p` (`n` is `p` delayed by half a clk period).
  - `clk_out = p | n`, giving high time (N/2)*Tclk, i.e. exactly 50%.
  - The OR is the only combinational path to the output.
- Reset (`rst_n` low, asynchronous):
  - `count` = 0, `p` = 0, `n` = 0, so `clk_out` = 0 immediately, independent of clk.
- Reset release:
  - The first rising edge takes `count` 0 -> 1.
  - For N=4, `clk_out` rises on the 2nd rising edge after release and falls on the 4th.
  - Thereafter the period is 4 clk cycles, with rising edges at release edges 2, 6, 10, ...
- Reset asserted mid-period: `clk_out` drops to 0 at once. The sequence restarts from `count` = 0 on release; no partial-period memory.
- Release timing: `rst_n` deasserts away from the rising clk edge (the bench releases on the falling edge). Release synchronization is the integrator's responsibility.
- Latency: `clk_out` transitions occur at the rising clk edge (or the falling edge for the odd-N trailing edge), with register clock-to-q delay only.
- No enable, no load; the counter runs freely whenever out of reset.

Test Plan:
- N=4, 10 ns clk, `rst_n` low at t=0, released at first falling edge:
  - `clk_out` = 0 during reset.
  - `clk_out` rises at the 2nd rising edge after release.
  - Thereafter period 40 ns, high 20 ns / low 20 ns.
- N=4, assert `rst_n` while `clk_out` = 1:
  - `clk_out` goes 0 without waiting for a clk edge.
  - After release, the first rise is again at the 2nd rising edge.
- N=4, run 1000 clk cycles: exactly 250 `clk_out` rising edges, no drift, no glitches (no pulse shorter than 20 ns).
- N=2 build: `clk_out` toggles every rising edge, period 20 ns, 50% duty; first rise at the 1st rising edge after release.
- N=3 build: period 30 ns, high 15 ns / low 15 ns; `clk_out` rises on a rising clk edge and falls on a falling clk edge.
- N=1 build: elaboration fails with a parameter error.

Source files
------------

// File: rtl/synch_modn_counter_4.sv
// Synchronous modulo-N clock divider with a 50% duty-cycle output.
//
// clk_out runs at f(clk)/N. A free-running counter wraps at N-1. A rising-edge
// register p is high for floor(N/2) cycles of every N. For odd N a falling-edge
// copy of p is ORed in, which stretches the high time by half a clk period.
//
// Parameters:
//   N   division ratio, must be >= 2 (default 4)
//   CW  counter width, derived from N; do not override
//
// Ports:
//   clk      system clock; rising edge for all state, falling edge for odd-N stretch
//   rst_n    asynchronous active-low reset; forces clk_out low immediately
//   clk_out  divided clock, period N*Tclk, 50% duty
`timescale 1ns / 1ps

module synch_modn_counter_4 #(
  parameter int unsigned N  = 4,
  parameter int          CW = $clog2(N)
) (
  input  logic clk,
  input  logic rst_n,
  output logic clk_out
);

  if (N < 2) begin : g_bad_n
    $error("synch_modn_counter_4: N must be >= 2, got %0d", N);
  end

  // Keeps widths legal while elaboration reports a bad N.
  localparam int CntW = (CW < 1) ? 1 : CW;

  localparam logic [CntW-1:0] LastCount = CntW'(N - 1);
  // ceil(N/2): p is high while the next count sits in the upper floor(N/2) slots.
  localparam logic [CntW-1:0] Threshold = CntW'((N + 1) / 2);

  logic [CntW-1:0] count_q, count_d;
  logic            p_q;

  always_comb begin
    count_d = (count_q == LastCount) ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      p_q     <= 1'b0;
    end else begin
      count_q <= count_d;
      p_q     <= (count_d >= Threshold);
    end
  end

  if (N % 2 == 1) begin : g_odd
    logic n_q;

    // Half-period delayed copy of p, used to extend the high phase.
    always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
        n_q <= 1'b0;
      end else begin
        n_q <= p_q;
      end
    end

    assign clk_out = p_q | n_q;
  end else begin : g_even
    assign clk_out = p_q;
  end

endmodule

// File: tb/tb_synch_modn_counter_4.sv
`timescale 1ns / 1ps

module tb_synch_modn_counter_4;

  logic clk;
  logic rst_n;
  logic out4, out2, out3;

  int checks = 0;
  int errors = 0;

  synch_modn_counter_4 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_out (out4)
  );

  synch_modn_counter_4 #(.N(2)) dut_n2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_out (out2)
  );

  synch_modn_counter_4 #(.N(3)) dut_n3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_out (out3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard entry: expected outputs of all three dividers at one sample point.
  typedef struct {
    int   k;
    bit   fall;
    logic e4;
    logic e2;
    logic e3;
  } exp_t;

  exp_t sb[$];
  int   k;  // rising edges since last reset release

  // Position-based reference: after release edge k, where is each divider in its period?
  function automatic logic model(int n, int kk, bit fall);
    int m;
    int t;
    if (kk < 1) return 1'b0;
    m = kk % n;
    t = (n + 1) / 2;
    if (n % 2 == 0) return (m >= n / 2);
    if (fall) return (m >= t);
    // rising half: current p, or trailing half-cycle from previous p (slot 0 follows slot N-1)
    return (m >= t) || (m == 0);
  endfunction

  function automatic exp_t mk_exp(int kk, bit fall);
    exp_t e;
    e.k    = kk;
    e.fall = fall;
    e.e4   = model(4, kk, fall);
    e.e2   = model(2, kk, fall);
    e.e3   = model(3, kk, fall);
    return e;
  endfunction

  task automatic tick_rise();
    @(posedge clk);
    k++;
    sb.push_back(mk_exp(k, 1'b0));
  endtask

  task automatic tick_fall();
    @(negedge clk);
    sb.push_back(mk_exp(k, 1'b1));
  endtask

  // Pulse-width / edge-count monitor state, index 0:N=4, 1:N=2, 2:N=3
  bit  mon_en = 1'b0;
  bit  have_t [3];
  time last_t [3];
  int  min_w  [3];
  int  max_w  [3];
  int  rises  [3];

  task automatic mon_update(int idx, logic v);
    time now;
    int  w;
    now = $time;
    if (!mon_en) return;
    if (have_t[idx]) begin
      w = int'(now - last_t[idx]);
      if (w < min_w[idx]) min_w[idx] = w;
      if (w > max_w[idx]) max_w[idx] = w;
    end
    have_t[idx] = 1'b1;
    last_t[idx] = now;
    if (v === 1'b1) rises[idx]++;
  endtask

  always @(out4) mon_update(0, out4);
  always @(out2) mon_update(1, out2);
  always @(out3) mon_update(2, out3);

  task automatic test_reset();
    rst_n = 1'b0;
    k     = 0;
    #1;
    checks++;
    if ({out4, out2, out3} !== 3'b000) begin
      errors++;
      $display("FAIL reset_t1: got %b%b%b want 000", out4, out2, out3);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({out4, out2, out3} !== 3'b000) begin
      errors++;
      $display("FAIL reset_clocked: got %b%b%b want 000", out4, out2, out3);
    end
  endtask

  task automatic test_release_sequence();
    exp_t e;
    @(negedge clk);
    rst_n = 1'b0;
    rst_n = 1'b1;
    k     = 0;
    for (int i = 0; i < 24; i++) begin
      tick_rise();
      #1;
      e = sb.pop_front();
      checks++;
      if ({out4, out2, out3} !== {e.e4, e.e2, e.e3}) begin
        errors++;
        $display("FAIL release_rise k=%0d: got %b%b%b want %b%b%b",
                 e.k, out4, out2, out3, e.e4, e.e2, e.e3);
      end
      tick_fall();
      #1;
      e = sb.pop_front();
      checks++;
      if ({out4, out2, out3} !== {e.e4, e.e2, e.e3}) begin
        errors++;
        $display("FAIL release_fall k=%0d: got %b%b%b want %b%b%b",
                 e.k, out4, out2, out3, e.e4, e.e2, e.e3);
      end
    end
  endtask

  task automatic test_reset_mid_period();
    exp_t e;
    bit   found;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick_rise();
      #1;
      e = sb.pop_front();
      checks++;
      if ({out4, out2, out3} !== {e.e4, e.e2, e.e3}) begin
        errors++;
        $display("FAIL mid_seek k=%0d: got %b%b%b want %b%b%b",
                 e.k, out4, out2, out3, e.e4, e.e2, e.e3);
      end
      if (out4 === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_seek_timeout: got clk_out=%b want 1 within 8 edges", out4);
    end
    // Assert reset between clock edges; output must drop with no edge.
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out4, out2, out3} !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset_async: got %b%b%b want 000", out4, out2, out3);
    end
    @(negedge clk);
    rst_n = 1'b1;
    k     = 0;
    for (int i = 0; i < 12; i++) begin
      tick_rise();
      #1;
      e = sb.pop_front();
      checks++;
      if ({out4, out2, out3} !== {e.e4, e.e2, e.e3}) begin
        errors++;
        $display("FAIL mid_restart_rise k=%0d: got %b%b%b want %b%b%b",
                 e.k, out4, out2, out3, e.e4, e.e2, e.e3);
      end
      tick_fall();
      #1;
      e = sb.pop_front();
      checks++;
      if ({out4, out2, out3} !== {e.e4, e.e2, e.e3}) begin
        errors++;
        $display("FAIL mid_restart_fall k=%0d: got %b%b%b want %b%b%b",
                 e.k, out4, out2, out3, e.e4, e.e2, e.e3);
      end
    end
  endtask

  task automatic test_long_run();
    int exp_rises [3];
    int exp_w     [3];
    exp_rises = '{250, 500, 333};
    exp_w     = '{20, 10, 15};
    #3;
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      have_t[i] = 1'b0;
      min_w[i]  = 1000000;
      max_w[i]  = 0;
      rises[i]  = 0;
    end
    mon_en = 1'b1;
    rst_n  = 1'b1;
    repeat (1000) @(posedge clk);
    #1;
    mon_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rises[i] !== exp_rises[i]) begin
        errors++;
        $display("FAIL long_rises[%0d]: got %0d want %0d", i, rises[i], exp_rises[i]);
      end
      checks++;
      if (min_w[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL long_min_width[%0d]: got %0d want %0d", i, min_w[i], exp_w[i]);
      end
      checks++;
      if (max_w[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL long_max_width[%0d]: got %0d want %0d", i, max_w[i], exp_w[i]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    k     = 0;
    test_reset();
    test_release_sequence();
    test_reset_mid_period();
    test_long_run();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case a wait never returns.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
